// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero r0 and a busy scoreboard.
module regfile_param #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ReadReg1,
  input  logic [AW-1:0]    ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             Busy1,
  output logic             Busy2,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Reserve,
  input  logic [AW-1:0]    ReserveReg,
  output logic [DEPTH-1:0] BusyVec
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_hit1, wr_hit2, rsv_hit1, rsv_hit2, zero1, zero2;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (RegWrite && !(ZERO_R0 && (WriteReg == '0))) begin
      regs_d[WriteReg] = WriteData;
    end
    // A new reservation supersedes a writeback from the previous producer.
    for (int i = 0; i < DEPTH; i++) begin
      if (Reserve && (ReserveReg == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (RegWrite && (WriteReg == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_R0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    zero1    = ZERO_R0 && (ReadReg1 == '0);
    zero2    = ZERO_R0 && (ReadReg2 == '0);
    wr_hit1  = BYPASS && RegWrite && (WriteReg == ReadReg1);
    wr_hit2  = BYPASS && RegWrite && (WriteReg == ReadReg2);
    rsv_hit1 = Reserve && (ReserveReg == ReadReg1);
    rsv_hit2 = Reserve && (ReserveReg == ReadReg2);

    ReadData1 = regs_q[ReadReg1];
    ReadData2 = regs_q[ReadReg2];
    Busy1     = busy_q[ReadReg1];
    Busy2     = busy_q[ReadReg2];

    if (wr_hit1) begin
      ReadData1 = WriteData;
      if (!rsv_hit1) Busy1 = 1'b0;
    end
    if (wr_hit2) begin
      ReadData2 = WriteData;
      if (!rsv_hit2) Busy2 = 1'b0;
    end
    // Reset must mask the bypass path too, not only the stored state.
    if (zero1 || reset) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
    if (zero2 || reset) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

  assign BusyVec = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default build, BYPASS=0 build and a
// WIDTH=16/DEPTH=4 build checked against a small reference model.
module tb_regfile_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default build
  logic [2:0]  rr1 = '0, rr2 = '0, wr = '0, rsr = '0;
  logic [31:0] rd1, rd2, wd = '0;
  logic        bz1, bz2, we = 1'b0, rs = 1'b0;
  logic [7:0]  bv;

  // BYPASS=0 build
  logic [2:0]  n_rr1 = '0, n_rr2 = '0, n_wr = '0, n_rsr = '0;
  logic [31:0] n_rd1, n_rd2, n_wd = '0;
  logic        n_bz1, n_bz2, n_we = 1'b0, n_rs = 1'b0;
  logic [7:0]  n_bv;

  // WIDTH=16, DEPTH=4 build
  logic [1:0]  s_rr1 = '0, s_rr2 = '0, s_wr = '0, s_rsr = '0;
  logic [15:0] s_rd1, s_rd2, s_wd = '0;
  logic        s_bz1, s_bz2, s_we = 1'b0, s_rs = 1'b0;
  logic [3:0]  s_bv;

  regfile_param dut (
    .clk(clk), .reset(reset),
    .ReadReg1(rr1), .ReadReg2(rr2), .ReadData1(rd1), .ReadData2(rd2),
    .Busy1(bz1), .Busy2(bz2), .RegWrite(we), .WriteReg(wr), .WriteData(wd),
    .Reserve(rs), .ReserveReg(rsr), .BusyVec(bv)
  );

  regfile_param #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset),
    .ReadReg1(n_rr1), .ReadReg2(n_rr2), .ReadData1(n_rd1), .ReadData2(n_rd2),
    .Busy1(n_bz1), .Busy2(n_bz2), .RegWrite(n_we), .WriteReg(n_wr), .WriteData(n_wd),
    .Reserve(n_rs), .ReserveReg(n_rsr), .BusyVec(n_bv)
  );

  regfile_param #(.WIDTH(16), .DEPTH(4)) dut_s (
    .clk(clk), .reset(reset),
    .ReadReg1(s_rr1), .ReadReg2(s_rr2), .ReadData1(s_rd1), .ReadData2(s_rd2),
    .Busy1(s_bz1), .Busy2(s_bz2), .RegWrite(s_we), .WriteReg(s_wr), .WriteData(s_wd),
    .Reserve(s_rs), .ReserveReg(s_rsr), .BusyVec(s_bv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] m_reg [4];
  logic [3:0]  m_busy;
  logic [15:0] e_rd1, e_rd2;
  logic        e_b1, e_b2;
  int          sweep_bad;

  initial begin
    // Reset state
    rr1 = 3'd3; rr2 = 3'd5;
    #2;
    chk("reset_rd1", 64'(rd1), 64'h0);
    chk("reset_bv", 64'(bv), 64'h0);
    chk("reset_busy1", 64'(bz1), 64'h0);
    // Bypass path is masked while reset is high.
    we = 1'b1; wr = 3'd3; wd = 32'h1234_5678; #1;
    chk("reset_bypass_rd1", 64'(rd1), 64'h0);
    @(negedge clk);
    we = 1'b0; reset = 1'b0;

    // Reset mid-operation
    tick();
    we = 1'b1; wr = 3'd3; wd = 32'hAFAF_AFAF;
    tick();
    we = 1'b0; rs = 1'b1; rsr = 3'd3;
    tick();
    rs = 1'b0; #1;
    chk("pre_reset_rd1", 64'(rd1), 64'hAFAF_AFAF);
    chk("pre_reset_bv", 64'(bv), 64'h08);
    #2 reset = 1'b1; #1;
    chk("async_reset_rd1", 64'(rd1), 64'h0);
    chk("async_reset_bv", 64'(bv), 64'h0);
    #1 reset = 1'b0;

    // Write r1..r7, then r0 (dropped)
    tick();
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; wr = 3'(i); wd = 32'h1000_0000 + 32'(i);
      tick();
    end
    wr = 3'd0; wd = 32'hFFFF_FFFF;
    #1;
    rr1 = 3'd0; #1;
    chk("r0_bypass_blocked", 64'(rd1), 64'h0);
    tick();
    we = 1'b0;
    rr1 = 3'd1; rr2 = 3'd7; #1;
    chk("read_r1", 64'(rd1), 64'h1000_0001);
    chk("read_r7", 64'(rd2), 64'h1000_0007);
    rr1 = 3'd2; rr2 = 3'd6; #1;
    chk("read_r2", 64'(rd1), 64'h1000_0002);
    chk("read_r6", 64'(rd2), 64'h1000_0006);
    rr1 = 3'd0; #1;
    chk("read_r0_zero", 64'(rd1), 64'h0);

    // Bypass on, and the same scenario with bypass off
    n_we = 1'b1; n_wr = 3'd5; n_wd = 32'h1234_5678;
    tick();
    n_we = 1'b0;
    we = 1'b1; wr = 3'd5; wd = 32'hDEAD_BEEF; rr2 = 3'd5;
    n_we = 1'b1; n_wr = 3'd5; n_wd = 32'hDEAD_BEEF; n_rr2 = 3'd5;
    #1;
    chk("bypass_rd2", 64'(rd2), 64'hDEAD_BEEF);
    chk("nobypass_old_rd2", 64'(n_rd2), 64'h1234_5678);
    tick();
    we = 1'b0; n_we = 1'b0; #1;
    chk("bypass_after_edge", 64'(rd2), 64'hDEAD_BEEF);
    chk("nobypass_after_edge", 64'(n_rd2), 64'hDEAD_BEEF);

    // Scoreboard reserve then writeback
    rs = 1'b1; rsr = 3'd4; rr1 = 3'd4;
    tick();
    rs = 1'b0; #1;
    chk("reserve_bv", 64'(bv), 64'h10);
    chk("reserve_busy1", 64'(bz1), 64'h1);
    we = 1'b1; wr = 3'd4; wd = 32'h55; #1;
    chk("wb_busy1_comb", 64'(bz1), 64'h0);
    chk("wb_bv_before_edge", 64'(bv), 64'h10);
    tick();
    we = 1'b0; #1;
    chk("wb_bv_after_edge", 64'(bv), 64'h00);
    chk("wb_rd1", 64'(rd1), 64'h55);

    // Simultaneous reserve and writeback on r2
    rs = 1'b1; rsr = 3'd2; we = 1'b1; wr = 3'd2; wd = 32'h77; rr1 = 3'd2; #1;
    chk("rsv_wb_busy1_comb", 64'(bz1), 64'h0);
    tick();
    rs = 1'b0; we = 1'b0; #1;
    chk("rsv_wb_rd1", 64'(rd1), 64'h77);
    chk("rsv_wb_bv", 64'(bv), 64'h04);
    // Re-reserve a busy register and try to reserve r0
    rs = 1'b1; rsr = 3'd2;
    tick();
    rsr = 3'd0;
    tick();
    rs = 1'b0; rr1 = 3'd0; #1;
    chk("rereserve_r0_bv", 64'(bv), 64'h04);
    chk("r0_busy1", 64'(bz1), 64'h0);
    // Writeback with a fresh reserve of the same reg keeps Busy high.
    rr1 = 3'd2; we = 1'b1; wr = 3'd2; wd = 32'h99; rs = 1'b1; rsr = 3'd2; #1;
    chk("wb_rerserve_busy1", 64'(bz1), 64'h1);
    tick();
    we = 1'b0; rs = 1'b0;

    // Randomised sweep on the small build against a reference model
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_busy = '0;
    sweep_bad = 0;
    for (int c = 0; c < 1000; c++) begin
      s_we  = 1'($urandom_range(0, 1));
      s_wr  = 2'($urandom_range(0, 3));
      s_wd  = 16'($urandom);
      s_rs  = ($urandom_range(0, 3) == 0);
      s_rsr = 2'($urandom_range(0, 3));
      s_rr1 = 2'($urandom_range(0, 3));
      s_rr2 = 2'($urandom_range(0, 3));
      #1;
      e_rd1 = (s_rr1 == 2'd0) ? 16'h0 : (s_we && s_wr == s_rr1) ? s_wd : m_reg[s_rr1];
      e_rd2 = (s_rr2 == 2'd0) ? 16'h0 : (s_we && s_wr == s_rr2) ? s_wd : m_reg[s_rr2];
      e_b1  = (s_rr1 == 2'd0) ? 1'b0 :
              (s_we && s_wr == s_rr1 && !(s_rs && s_rsr == s_rr1)) ? 1'b0 : m_busy[s_rr1];
      e_b2  = (s_rr2 == 2'd0) ? 1'b0 :
              (s_we && s_wr == s_rr2 && !(s_rs && s_rsr == s_rr2)) ? 1'b0 : m_busy[s_rr2];
      if ({s_rd1, s_rd2, s_bz1, s_bz2, s_bv} !== {e_rd1, e_rd2, e_b1, e_b2, m_busy})
        sweep_bad++;
      chk("sweep", {26'h0, s_rd1, s_rd2, s_bz1, s_bz2, s_bv},
                   {26'h0, e_rd1, e_rd2, e_b1, e_b2, m_busy});
      if (sweep_bad > 5) begin
        $display("FAIL sweep aborted after %0d mismatches at cycle %0d", sweep_bad, c);
        break;
      end
      tick();
      if (s_we && s_wr != 2'd0) m_reg[s_wr] = s_wd;
      for (int i = 0; i < 4; i++) begin
        if (s_rs && s_rsr == 2'(i)) m_busy[i] = 1'b1;
        else if (s_we && s_wr == 2'(i)) m_busy[i] = 1'b0;
      end
      m_busy[0] = 1'b0;
    end
    s_we = 1'b0; s_rs = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
